sdram_cmd_responder: RTL and testbench

//  Target-side SDRAM responder: the device end of the sd0_* controller pins (RAS/CAS/WE,

---
 rtl/sdram_cmd_responder_if.sv | 43 ++++
 rtl/sdram_cmd_responder.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_cmd_responder.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_responder_if.sv
// SDRAM pin bundle plus backend store port for the command responder.
// slave = responder side, master = controller/backend side.
interface sdram_cmd_responder_if #(
  parameter int DW    = 64,
  parameter int COL_W = 8
);
  logic                  sd_cs_;
  logic                  sd_ras_;
  logic                  sd_cas_;
  logic                  sd_we_;
  logic [1:0]            sd_ba;
  logic [11:0]           sd_adrs;
  logic [DW/8-1:0]       sd_dqm_l;
  logic [DW-1:0]         sd_dq_in;
  logic [DW-1:0]         sd_dq_out;
  logic [DW/8-1:0]       sd_dq_oe;
  logic                  be_req;
  logic                  be_we;
  logic [14+COL_W-1:0]   be_addr;
  logic [DW-1:0]         be_wdata;
  logic [DW/8-1:0]       be_wmask;
  logic [DW-1:0]         be_rdata;
  logic                  err_closed;
  logic                  err_open;

  modport slave (
    input  sd_cs_, sd_ras_, sd_cas_, sd_we_,
    input  sd_ba, sd_adrs, sd_dqm_l, sd_dq_in,
    input  be_rdata,
    output sd_dq_out, sd_dq_oe,
    output be_req, be_we, be_addr, be_wdata, be_wmask,
    output err_closed, err_open
  );

  modport master (
    output sd_cs_, sd_ras_, sd_cas_, sd_we_,
    output sd_ba, sd_adrs, sd_dqm_l, sd_dq_in,
    output be_rdata,
    input  sd_dq_out, sd_dq_oe,
    input  be_req, be_we, be_addr, be_wdata, be_wmask,
    input  err_closed, err_open
  );
endinterface

// File: rtl/sdram_cmd_responder.sv
// SDRAM target-side responder: decodes pin commands, tracks open rows,
// turns bursts into backend beats and returns read data after CL.
module sdram_cmd_responder #(
  parameter int CL    = 2,
  parameter int BL    = 4,
  parameter int COL_W = 8,
  parameter int DW    = 64
) (
  input logic                  clk,
  input logic                  rst_l,
  sdram_cmd_responder_if.slave bus
);
  localparam int MW = DW / 8;
  localparam int AW = 14 + COL_W;
  localparam logic [COL_W-1:0] MSK = COL_W'(BL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST
  } state_t;

  state_t           state;
  logic [1:0]       bk;
  logic [11:0]      row;
  logic [COL_W-1:0] col;
  logic [3:0]       k;
  logic             ap;
  logic [3:0]       open_q;
  logic [3:0]       open_d;
  logic [11:0]      rows [4];
  logic [MW-1:0]    rd_oe;

  logic [2:0]       cmd;
  logic             is_act;
  logic             is_rd;
  logic             is_wr;
  logic             is_pre;
  logic             legal_rw;
  logic             last_beat;
  logic             ap_close;
  logic             go;
  logic             go_we;
  logic [AW-1:0]    go_addr;

  function automatic logic [COL_W-1:0] wrap(
    input logic [COL_W-1:0] c,
    input logic [3:0]       n
  );
    return (c & ~MSK) | ((c + COL_W'(n)) & MSK);
  endfunction

  assign cmd = {bus.sd_ras_, bus.sd_cas_, bus.sd_we_};

  always_comb begin
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    unique case (1'b1)
      (!bus.sd_cs_ && cmd == 3'b011): is_act = 1'b1;
      (!bus.sd_cs_ && cmd == 3'b101): is_rd  = 1'b1;
      (!bus.sd_cs_ && cmd == 3'b100): is_wr  = 1'b1;
      (!bus.sd_cs_ && cmd == 3'b010): is_pre = 1'b1;
      default: ;
    endcase
  end

  assign legal_rw  = (is_rd | is_wr) & open_q[bus.sd_ba];
  assign last_beat = (state != IDLE) && (k == 4'(BL - 1));
  // auto-precharge fires on the final beat or when a new burst cuts in
  assign ap_close  = ap && (state != IDLE) && (legal_rw || last_beat);

  always_comb begin
    open_d = open_q;
    if (ap_close)
      open_d[bk] = 1'b0;
    if (legal_rw && bus.sd_adrs[10] && BL == 1)
      open_d[bus.sd_ba] = 1'b0;
    if (is_act)
      open_d[bus.sd_ba] = 1'b1;
    if (is_pre) begin
      if (bus.sd_adrs[10])
        open_d = '0;
      else
        open_d[bus.sd_ba] = 1'b0;
    end
  end

  always_comb begin
    go      = 1'b0;
    go_we   = 1'b0;
    go_addr = '0;
    if (legal_rw) begin
      go      = 1'b1;
      go_we   = is_wr;
      go_addr = {bus.sd_ba, rows[bus.sd_ba],
                 bus.sd_adrs[COL_W-1:0]};
    end else if (state != IDLE) begin
      go      = 1'b1;
      go_we   = (state == WR_BURST);
      go_addr = {bk, row, wrap(col, k)};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state          <= IDLE;
      bk             <= '0;
      row            <= '0;
      col            <= '0;
      k              <= '0;
      ap             <= 1'b0;
      open_q         <= '0;
      for (int i = 0; i < 4; i++)
        rows[i] <= '0;
      rd_oe          <= '0;
      bus.be_req     <= 1'b0;
      bus.be_we      <= 1'b0;
      bus.be_addr    <= '0;
      bus.be_wdata   <= '0;
      bus.be_wmask   <= '0;
      bus.err_closed <= 1'b0;
      bus.err_open   <= 1'b0;
    end else begin
      open_q <= open_d;
      if (is_act)
        rows[bus.sd_ba] <= bus.sd_adrs;
      bus.err_closed <= (is_rd | is_wr) & ~open_q[bus.sd_ba];
      bus.err_open   <= is_act & open_q[bus.sd_ba];
      bus.be_req     <= go;
      bus.be_we      <= go & go_we;
      bus.be_wdata   <= (go && go_we) ? bus.sd_dq_in : '0;
      bus.be_wmask   <= (go && go_we) ? ~bus.sd_dqm_l : '0;
      rd_oe          <= (go && !go_we) ? ~bus.sd_dqm_l : '0;
      if (go)
        bus.be_addr <= go_addr;
      if (legal_rw) begin
        state <= (BL == 1) ? IDLE
               : (is_wr ? WR_BURST : RD_BURST);
        bk    <= bus.sd_ba;
        row   <= rows[bus.sd_ba];
        col   <= bus.sd_adrs[COL_W-1:0];
        ap    <= bus.sd_adrs[10];
        k     <= 4'd1;
      end else if (last_beat) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        k <= k + 4'd1;
      end
    end
  end

  logic          v0;
  logic          out_v;
  logic [MW-1:0] out_oe;
  logic [DW-1:0] out_d;
  logic [DW-1:0] last_q;

  assign v0 = bus.be_req & ~bus.be_we;

  // stage 0 is the backend's combinational answer; CL-1 registers follow
  if (CL == 1) begin : g_cl1
    assign out_v  = v0;
    assign out_oe = rd_oe;
    assign out_d  = bus.be_rdata;
  end else begin : g_pipe
    logic [CL-2:0] v_q;
    logic [MW-1:0] oe_q [CL-1];
    logic [DW-1:0] d_q  [CL-1];

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        v_q <= '0;
        for (int i = 0; i < CL - 1; i++) begin
          oe_q[i] <= '0;
          d_q[i]  <= '0;
        end
      end else begin
        v_q[0]  <= v0;
        oe_q[0] <= rd_oe;
        d_q[0]  <= bus.be_rdata;
        for (int i = 1; i < CL - 1; i++) begin
          v_q[i]  <= v_q[i-1];
          oe_q[i] <= oe_q[i-1];
          d_q[i]  <= d_q[i-1];
        end
      end
    end

    assign out_v  = v_q[CL-2];
    assign out_oe = oe_q[CL-2];
    assign out_d  = d_q[CL-2];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      last_q <= '0;
    else if (out_v)
      last_q <= out_d;
  end

  assign bus.sd_dq_out = out_v ? out_d : last_q;
  assign bus.sd_dq_oe  = out_v ? out_oe : '0;
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed scenarios and random traffic
// compared cycle by cycle against a burst-schedule reference model.
module tb_sdram_cmd_responder;
  localparam int CL = 2;
  localparam int BL = 4;
  localparam int NC = 2048;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [21:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        ec;
    logic        eo;
    logic [7:0]  oe;
    logic [63:0] dq;
  } obs_t;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [1:0]  bank;
    logic [21:0] addr;
    logic        ap;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  obs_t        obs_o [NC];
  obs_t        exp_o [NC];
  beat_t       sched [NC];
  logic        dq_v  [NC];
  logic [7:0]  dq_oe [NC];
  logic [63:0] dq_d  [NC];
  logic [3:0]  m_open;
  logic [11:0] m_row [4];
  logic [63:0] m_last;

  always #5 clk = ~clk;

  sdram_cmd_responder_if #(.DW(64), .COL_W(8)) bif ();

  sdram_cmd_responder #(
    .CL(CL), .BL(BL), .COL_W(8), .DW(64)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bif)
  );

  function automatic logic [63:0] rd_fn(input logic [21:0] a);
    return {a ^ 22'h2AAAAA, 10'h3C5, a, 10'h1A3};
  endfunction

  assign bif.be_rdata = rd_fn(bif.be_addr);

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      obs_o[i] = '0;
      exp_o[i] = '0;
      sched[i] = '0;
      dq_v[i]  = 1'b0;
      dq_oe[i] = '0;
      dq_d[i]  = '0;
    end
    m_open = '0;
    for (int i = 0; i < 4; i++) m_row[i] = '0;
    m_last = '0;
    cyc = 0;
  endtask

  task automatic model_step(input int c);
    obs_t e;
    beat_t b;
    logic [2:0] cm;
    logic act, rd, wr, pre, rw;
    logic [1:0] ba;
    int off, base;
    cm  = {bif.sd_ras_, bif.sd_cas_, bif.sd_we_};
    ba  = bif.sd_ba;
    act = !bif.sd_cs_ && cm == 3'b011;
    rd  = !bif.sd_cs_ && cm == 3'b101;
    wr  = !bif.sd_cs_ && cm == 3'b100;
    pre = !bif.sd_cs_ && cm == 3'b010;
    rw  = rd || wr;
    e = '0;
    e.ec = rw && !m_open[ba];
    e.eo = act && m_open[ba];
    if (rw && m_open[ba]) begin
      if (sched[c].v && sched[c].ap) m_open[sched[c].bank] = 1'b0;
      off  = int'(bif.sd_adrs[7:0]) % BL;
      base = int'(bif.sd_adrs[7:0]) - off;
      for (int k = 0; k < BL; k++) begin
        b.v    = 1'b1;
        b.we   = wr;
        b.bank = ba;
        b.addr = {ba, m_row[ba], 8'(base + (off + k) % BL)};
        b.ap   = bif.sd_adrs[10];
        b.last = (k == BL - 1);
        sched[c+k] = b;
      end
    end
    b = sched[c];
    if (b.v) begin
      e.req  = 1'b1;
      e.we   = b.we;
      e.addr = b.addr;
      if (b.we) begin
        e.wdata = bif.sd_dq_in;
        e.wmask = ~bif.sd_dqm_l;
      end else begin
        dq_v[c+CL]  = 1'b1;
        dq_oe[c+CL] = ~bif.sd_dqm_l;
        dq_d[c+CL]  = rd_fn(b.addr);
      end
      if (b.last && b.ap) m_open[b.bank] = 1'b0;
    end
    if (act) begin
      m_open[ba] = 1'b1;
      m_row[ba]  = bif.sd_adrs;
    end
    if (pre) begin
      if (bif.sd_adrs[10]) m_open = '0;
      else m_open[ba] = 1'b0;
    end
    if (dq_v[c+1]) begin
      e.oe   = dq_oe[c+1];
      m_last = dq_d[c+1];
    end
    e.dq = m_last;
    exp_o[c+1] = e;
  endtask

  task automatic tick(input logic [3:0] c4, input logic [1:0] ba,
                      input logic [11:0] a, input logic [7:0] m,
                      input logic [63:0] d);
    obs_t o;
    bif.sd_cs_   = c4[3];
    bif.sd_ras_  = c4[2];
    bif.sd_cas_  = c4[1];
    bif.sd_we_   = c4[0];
    bif.sd_ba    = ba;
    bif.sd_adrs  = a;
    bif.sd_dqm_l = m;
    bif.sd_dq_in = d;
    @(posedge clk);
    model_step(cyc);
    @(negedge clk);
    o = '0;
    o.req = bif.be_req;
    if (o.req) begin
      o.we   = bif.be_we;
      o.addr = bif.be_addr;
      if (o.we) begin
        o.wdata = bif.be_wdata;
        o.wmask = bif.be_wmask;
      end
    end
    o.ec = bif.err_closed;
    o.eo = bif.err_open;
    o.oe = bif.sd_dq_oe;
    o.dq = bif.sd_dq_out;
    obs_o[cyc+1] = o;
    cyc++;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) tick(C_NOP, 2'd0, 12'd0, 8'h00, 64'd0);
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_l = 1'b0;
    bif.sd_cs_ = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    checks++;
    if ({bif.be_req, bif.be_we, bif.be_addr, bif.be_wdata, bif.be_wmask,
         bif.err_closed, bif.err_open, bif.sd_dq_oe, bif.sd_dq_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b oe=%h dq=%h exp all zero",
               bif.be_req, bif.sd_dq_oe, bif.sd_dq_out);
    end
    reset_all();
    nops(4);
    for (int n = 1; n <= cyc; n++) begin
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
  endtask

  task automatic test_read_burst();
    int c0;
    logic [7:0] cols [4];
    cols = '{8'h06, 8'h07, 8'h04, 8'h05};
    reset_all();
    tick(C_ACT, 2'd1, 12'h2A5, 8'h00, 64'd0);
    nops(1);
    c0 = cyc;
    tick(C_RD, 2'd1, 12'h006, 8'h00, 64'd0);
    nops(8);
    for (int n = 1; n <= cyc; n++) begin
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL read_burst cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_o[c0+1+k].addr !== {2'd1, 12'h2A5, cols[k]} ||
          obs_o[c0+2+k].oe !== 8'hFF) begin
        failures++;
        $display("FAIL read_cols k=%0d got addr=%h oe=%h exp col=%h oe=ff",
                 k, obs_o[c0+1+k].addr, obs_o[c0+2+k].oe, cols[k]);
      end
    end
  endtask

  task automatic test_write_burst();
    int c0;
    logic [7:0]  dqm [4];
    logic [7:0]  msk [4];
    logic [63:0] d   [4];
    dqm = '{8'h00, 8'h0F, 8'hFF, 8'hF0};
    msk = '{8'hFF, 8'hF0, 8'h00, 8'h0F};
    for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
    reset_all();
    tick(C_ACT, 2'd0, 12'd5, 8'h00, 64'd0);
    c0 = cyc;
    tick(C_WR, 2'd0, 12'h010, dqm[0], d[0]);
    for (int k = 1; k < 4; k++) tick(C_NOP, 2'd0, 12'd0, dqm[k], d[k]);
    nops(4);
    for (int n = 1; n <= cyc; n++) begin
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL write_burst cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_o[c0+1+k].req !== 1'b1 || obs_o[c0+1+k].we !== 1'b1 ||
          obs_o[c0+1+k].wmask !== msk[k] || obs_o[c0+1+k].wdata !== d[k]) begin
        failures++;
        $display("FAIL write_beat k=%0d got mask=%h data=%h exp mask=%h data=%h",
                 k, obs_o[c0+1+k].wmask, obs_o[c0+1+k].wdata, msk[k], d[k]);
      end
    end
  endtask

  task automatic test_errors();
    int c0, ca, cb, nerr, nreq;
    reset_all();
    c0 = cyc;
    tick(C_RD, 2'd2, 12'h000, 8'h00, 64'd0);
    nops(3);
    ca = cyc;
    tick(C_ACT, 2'd2, 12'h011, 8'h00, 64'd0);
    nops(1);
    cb = cyc;
    tick(C_ACT, 2'd2, 12'h022, 8'h00, 64'd0);
    nops(3);
    nerr = 0;
    nreq = 0;
    for (int n = 1; n <= cyc; n++) begin
      nerr += int'(obs_o[n].ec);
      nreq += int'(obs_o[n].req);
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL errors cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
    checks++;
    if (nerr != 1 || obs_o[c0+1].ec !== 1'b1 || nreq != 0) begin
      failures++;
      $display("FAIL err_closed got pulses=%0d reqs=%0d exp 1 and 0", nerr, nreq);
    end
    checks++;
    if (obs_o[ca+1].eo !== 1'b0 || obs_o[cb+1].eo !== 1'b1) begin
      failures++;
      $display("FAIL err_open got first=%b second=%b exp 0 1",
               obs_o[ca+1].eo, obs_o[cb+1].eo);
    end
  endtask

  task automatic test_interrupt();
    int c0;
    reset_all();
    tick(C_ACT, 2'd0, 12'h155, 8'h00, 64'd0);
    c0 = cyc;
    tick(C_RD, 2'd0, 12'h000, 8'h00, 64'd0);
    nops(1);
    tick(C_WR, 2'd0, 12'h008, 8'h00, 64'h1111);
    for (int k = 1; k < 4; k++) tick(C_NOP, 2'd0, 12'd0, 8'h00, 64'(k));
    nops(5);
    for (int n = 1; n <= cyc; n++) begin
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL interrupt cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
    checks++;
    if (obs_o[c0+2].oe !== 8'hFF || obs_o[c0+3].oe !== 8'hFF ||
        obs_o[c0+4].oe !== 8'h00 ||
        obs_o[c0+3].dq !== rd_fn({2'd0, 12'h155, 8'h01})) begin
      failures++;
      $display("FAIL intr_drain got oe=%h,%h,%h exp ff,ff,00",
               obs_o[c0+2].oe, obs_o[c0+3].oe, obs_o[c0+4].oe);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_o[c0+3+k].we !== 1'b1 || obs_o[c0+3+k].addr[7:0] !== 8'(8 + k)) begin
        failures++;
        $display("FAIL intr_write k=%0d got we=%b col=%h exp 1 %h",
                 k, obs_o[c0+3+k].we, obs_o[c0+3+k].addr[7:0], 8 + k);
      end
    end
  endtask

  task automatic test_auto_precharge();
    int c0, cp;
    reset_all();
    tick(C_ACT, 2'd3, 12'h0AB, 8'h00, 64'd0);
    c0 = cyc;
    tick(C_RD, 2'd3, 12'h400, 8'h00, 64'd0);
    nops(3);
    tick(C_RD, 2'd3, 12'h000, 8'h00, 64'd0);
    tick(C_ACT, 2'd0, 12'h001, 8'h00, 64'd0);
    tick(C_ACT, 2'd1, 12'h002, 8'h00, 64'd0);
    tick(C_REF, 2'd0, 12'h000, 8'h00, 64'd0);
    tick(C_PRE, 2'd2, 12'h400, 8'h00, 64'd0);
    cp = cyc;
    tick(C_RD, 2'd1, 12'h000, 8'h00, 64'd0);
    nops(4);
    for (int n = 1; n <= cyc; n++) begin
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL auto_pre cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
    checks++;
    if (obs_o[c0+5].ec !== 1'b1 || obs_o[c0+5].req !== 1'b0 ||
        obs_o[cp+1].ec !== 1'b1 || obs_o[cp+1].req !== 1'b0) begin
      failures++;
      $display("FAIL precharge_close got ap_err=%b pall_err=%b exp 1 1",
               obs_o[c0+5].ec, obs_o[cp+1].ec);
    end
  endtask

  task automatic test_reset_mid_burst();
    int nreq, nerr;
    reset_all();
    tick(C_ACT, 2'd0, 12'h033, 8'h00, 64'd0);
    tick(C_WR, 2'd0, 12'h020, 8'h00, 64'hAAAA);
    tick(C_NOP, 2'd0, 12'h000, 8'h00, 64'hBBBB);
    rst_l = 1'b0;
    #1;
    checks++;
    if ({bif.be_req, bif.be_we, bif.be_addr, bif.be_wdata, bif.be_wmask,
         bif.err_closed, bif.err_open, bif.sd_dq_oe, bif.sd_dq_out} !== '0) begin
      failures++;
      $display("FAIL mid_reset got req=%b addr=%h wdata=%h exp all zero",
               bif.be_req, bif.be_addr, bif.be_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    model_clear();
    nops(3);
    tick(C_RD, 2'd0, 12'h000, 8'h00, 64'd0);
    nops(5);
    nreq = 0;
    nerr = 0;
    for (int n = 1; n <= cyc; n++) begin
      nreq += int'(obs_o[n].req);
      nerr += int'(obs_o[n].ec);
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
    checks++;
    if (nreq != 0 || nerr != 1) begin
      failures++;
      $display("FAIL post_reset_beats got reqs=%0d errs=%0d exp 0 1", nreq, nerr);
    end
  endtask

  task automatic test_random();
    logic [3:0]  c4;
    logic [11:0] a;
    int r;
    reset_all();
    for (int b = 0; b < 4; b++)
      tick(C_ACT, 2'(b), 12'($urandom), 8'h00, 64'd0);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      a = 12'($urandom);
      if (r < 30)      c4 = C_NOP;
      else if (r < 45) c4 = C_ACT;
      else if (r < 65) c4 = C_RD;
      else if (r < 85) c4 = C_WR;
      else if (r < 92) c4 = C_PRE;
      else if (r < 95) c4 = C_REF;
      else if (r < 97) c4 = C_MRS;
      else             c4 = {1'b1, 3'($urandom)};
      if ((c4 == C_RD || c4 == C_WR) && $urandom_range(0, 3) != 0) a[10] = 1'b0;
      tick(c4, 2'($urandom), a, 8'($urandom), {$urandom, $urandom});
    end
    nops(8);
    for (int n = 1; n <= cyc; n++) begin
      checks++;
      if (obs_o[n] !== exp_o[n]) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", n, obs_o[n], exp_o[n]);
      end
    end
  endtask

  initial begin
    bif.sd_cs_   = 1'b1;
    bif.sd_ras_  = 1'b1;
    bif.sd_cas_  = 1'b1;
    bif.sd_we_   = 1'b1;
    bif.sd_ba    = '0;
    bif.sd_adrs  = '0;
    bif.sd_dqm_l = '0;
    bif.sd_dq_in = '0;
    model_clear();
    #2;
    test_reset();
    test_read_burst();
    test_write_burst();
    test_errors();
    test_interrupt();
    test_auto_precharge();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
